// File: rtl/nvram_uploader.sv
// Serves the 1Kx4 CMOS NVRAM to the HPS over the ioctl upload path, one nibble per byte,
// and requests an automatic upload once CPU writes to the CMOS have been quiet for HOLD cycles.
module nvram_uploader #(
  parameter int unsigned ADDR_W   = 10,
  parameter logic [7:0]  NV_INDEX = 8'd4,
  parameter logic [23:0] HOLD     = 24'd12_000_000
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_upload,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic [16:0]       ioctl_addr,
  input  logic              ioctl_rd,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic              ioctl_upload_req,
  input  logic              cpu_cmos_we,
  output logic [ADDR_W-1:0] nv_addr,
  output logic              nv_rd,
  input  logic [3:0]        nv_q,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, FETCH, LATCH} state_t;

  state_t            state, state_nxt;
  logic [7:0]        din_nxt;
  logic              wait_nxt, rd_nxt, busy_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              oor, oor_nxt;

  logic              sel, sel_d, in_range, bus_quiet;
  logic              dirty, dirty_nxt, req_nxt;
  logic [23:0]       cnt, cnt_nxt;

  assign sel       = ioctl_upload & (ioctl_index == NV_INDEX);
  assign in_range  = (ioctl_addr >> ADDR_W) == '0;
  assign bus_quiet = ~ioctl_upload & ~ioctl_download;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      ioctl_din        <= 8'h00;
      ioctl_wait       <= 1'b0;
      nv_rd            <= 1'b0;
      nv_addr          <= '0;
      busy             <= 1'b0;
      oor              <= 1'b0;
      sel_d            <= 1'b0;
      dirty            <= 1'b0;
      cnt              <= '0;
      ioctl_upload_req <= 1'b0;
    end else begin
      state            <= state_nxt;
      ioctl_din        <= din_nxt;
      ioctl_wait       <= wait_nxt;
      nv_rd            <= rd_nxt;
      nv_addr          <= addr_nxt;
      busy             <= busy_nxt;
      oor              <= oor_nxt;
      sel_d            <= sel;
      dirty            <= dirty_nxt;
      cnt              <= cnt_nxt;
      ioctl_upload_req <= req_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    din_nxt   = ioctl_din;
    wait_nxt  = ioctl_wait;
    rd_nxt    = 1'b0;
    addr_nxt  = nv_addr;
    oor_nxt   = oor;
    case (state)
      IDLE: begin
        if (ioctl_rd && sel) begin
          wait_nxt  = 1'b1;
          state_nxt = FETCH;
          if (in_range) begin
            addr_nxt = ioctl_addr[ADDR_W-1:0];
            rd_nxt   = 1'b1;
            oor_nxt  = 1'b0;
          end else begin
            oor_nxt  = 1'b1;
          end
        end
      end
      // The CMOS registers its output, so one cycle passes before nv_q is usable.
      FETCH: state_nxt = LATCH;
      LATCH: begin
        din_nxt   = oor ? 8'hFF : {4'hF, nv_q};
        wait_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // A CPU write always wins; an upload start discards dirt since it captures current contents.
  always_comb begin
    dirty_nxt = dirty;
    cnt_nxt   = cnt;
    req_nxt   = 1'b0;
    if (cpu_cmos_we) begin
      dirty_nxt = 1'b1;
      cnt_nxt   = HOLD;
    end else if (sel && !sel_d) begin
      dirty_nxt = 1'b0;
    end else if (dirty && bus_quiet) begin
      if (cnt != '0) begin
        cnt_nxt = cnt - 24'd1;
      end else begin
        req_nxt   = 1'b1;
        dirty_nxt = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nvram_uploader.sv
// Scoreboard bench for nvram_uploader: a registered CMOS model, upload-byte queue checked
// whenever ioctl_wait falls, and cycle-counted windows for the auto upload request.
module tb_nvram_uploader;

  localparam int unsigned ADDR_W = 10;
  localparam logic [23:0] HOLD   = 24'd16;

  logic              clk_sys = 1'b0;
  logic              reset_n;
  logic              ioctl_upload, ioctl_download, ioctl_rd, cpu_cmos_we;
  logic [7:0]        ioctl_index;
  logic [16:0]       ioctl_addr;
  logic [7:0]        ioctl_din;
  logic              ioctl_wait, ioctl_upload_req, nv_rd, busy;
  logic [ADDR_W-1:0] nv_addr;
  logic [3:0]        nv_q = 4'h0;

  nvram_uploader #(
    .ADDR_W  (ADDR_W),
    .NV_INDEX(8'd4),
    .HOLD    (HOLD)
  ) dut (
    .clk_sys         (clk_sys),
    .reset_n         (reset_n),
    .ioctl_upload    (ioctl_upload),
    .ioctl_download  (ioctl_download),
    .ioctl_index     (ioctl_index),
    .ioctl_addr      (ioctl_addr),
    .ioctl_rd        (ioctl_rd),
    .ioctl_din       (ioctl_din),
    .ioctl_wait      (ioctl_wait),
    .ioctl_upload_req(ioctl_upload_req),
    .cpu_cmos_we     (cpu_cmos_we),
    .nv_addr         (nv_addr),
    .nv_rd           (nv_rd),
    .nv_q            (nv_q),
    .busy            (busy)
  );

  always #5 clk_sys = ~clk_sys;

  logic [3:0] mem [0:1023];
  always @(posedge clk_sys) if (nv_rd) nv_q <= mem[nv_addr];

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  logic [7:0] exp_q[$];
  int   reads_done  = 0;
  int   wait_len    = 0;
  int   nvrd_cycles = 0;
  logic prev_wait   = 1'b0;

  always @(negedge clk_sys) begin
    if (!reset_n) begin
      prev_wait = 1'b0;
      wait_len  = 0;
    end else begin
      if (nv_rd) nvrd_cycles++;
      if (ioctl_wait) wait_len++;
      if (prev_wait && !ioctl_wait) begin
        check("wait_len", 32'(wait_len), 32'd2);
        if (exp_q.size() == 0) begin
          check("extra_byte", 32'(exp_q.size()), 32'd1);
        end else begin
          check("din", 32'(ioctl_din), 32'(exp_q.pop_front()));
          reads_done++;
        end
        wait_len = 0;
      end
      prev_wait = ioctl_wait;
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (ioctl_wait && n < 10) begin
      tick();
      n++;
    end
    if (ioctl_wait) check("wait_timeout", 32'(ioctl_wait), 32'd0);
  endtask

  task automatic do_read(input logic [16:0] addr, input logic [7:0] expd);
    ioctl_addr = addr;
    ioctl_rd   = 1'b1;
    exp_q.push_back(expd);
    tick();
    ioctl_rd = 1'b0;
    wait_idle();
  endtask

  // Cycle k = 0 is the edge sampling the first write; a pulse seen after edge k is reported as k.
  task automatic req_window(input int we2_at, input int dl_from, input int dl_to,
                            input int up_from, input int up_to,
                            output int pulses, output int first_at);
    pulses   = 0;
    first_at = -1;
    for (int k = 0; k <= 70; k++) begin
      cpu_cmos_we    = (k == 0) || (k == we2_at);
      ioctl_download = (k >= dl_from) && (k <= dl_to);
      ioctl_upload   = (k >= up_from) && (k <= up_to);
      tick();
      if (ioctl_upload_req) begin
        pulses++;
        if (first_at < 0) first_at = k;
      end
    end
    cpu_cmos_we    = 1'b0;
    ioctl_download = 1'b0;
    ioctl_upload   = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int pulses, first_at, nv0;

    for (int i = 0; i < 1024; i++) mem[i] = 4'($urandom_range(0, 15));
    mem[5] = 4'hA;

    reset_n        = 1'b0;
    ioctl_upload   = 1'b0;
    ioctl_download = 1'b0;
    ioctl_index    = 8'd0;
    ioctl_addr     = '0;
    ioctl_rd       = 1'b0;
    cpu_cmos_we    = 1'b0;
    #12;
    check("rst_din",  32'(ioctl_din), 32'h00);
    check("rst_wait", 32'(ioctl_wait), 32'd0);
    check("rst_req",  32'(ioctl_upload_req), 32'd0);
    check("rst_nvrd", 32'(nv_rd), 32'd0);
    check("rst_addr", 32'(nv_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    ioctl_upload = 1'b1;
    ioctl_index  = 8'd4;
    tick();

    // Single read with explicit latency checks
    nv0        = nvrd_cycles;
    ioctl_addr = 17'h005;
    ioctl_rd   = 1'b1;
    exp_q.push_back(8'hFA);
    tick();
    ioctl_rd = 1'b0;
    check("t0_wait", 32'(ioctl_wait), 32'd1);
    check("t0_nvrd", 32'(nv_rd), 32'd1);
    check("t0_addr", 32'(nv_addr), 32'h005);
    check("t0_busy", 32'(busy), 32'd1);
    tick();
    check("t1_nvrd", 32'(nv_rd), 32'd0);
    check("t1_wait", 32'(ioctl_wait), 32'd1);
    tick();
    check("t2_wait", 32'(ioctl_wait), 32'd0);
    check("t2_din",  32'(ioctl_din), 32'hFA);
    check("t2_busy", 32'(busy), 32'd0);
    check("nvrd_once", 32'(nvrd_cycles - nv0), 32'd1);

    // Back-to-back full sweep
    for (int unsigned n = 0; n < 1024; n++) do_read(17'(n), {4'hF, mem[n]});

    // Out-of-range address
    tick();
    nv0 = nvrd_cycles;
    do_read(17'h400, 8'hFF);
    check("oor_din",  32'(ioctl_din), 32'hFF);
    check("oor_nvrd", 32'(nvrd_cycles - nv0), 32'd0);

    // Wrong index is ignored
    ioctl_index = 8'd0;
    ioctl_addr  = 17'h007;
    ioctl_rd    = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    check("rom_wait", 32'(ioctl_wait), 32'd0);
    check("rom_busy", 32'(busy), 32'd0);
    tick();
    check("rom_din", 32'(ioctl_din), 32'hFF);

    // Second strobe while a read is in flight is ignored
    ioctl_index = 8'd4;
    tick();
    ioctl_addr = 17'h009;
    ioctl_rd   = 1'b1;
    exp_q.push_back({4'hF, mem[9]});
    tick();
    check("busy_addr", 32'(nv_addr), 32'h009);
    ioctl_addr = 17'h020;
    tick();
    ioctl_rd = 1'b0;
    check("busy_addr2", 32'(nv_addr), 32'h009);
    wait_idle();
    tick();
    tick();
    check("busy_addr3", 32'(nv_addr), 32'h009);
    check("busy_wait3", 32'(ioctl_wait), 32'd0);

    ioctl_upload = 1'b0;
    tick();
    tick();
    check("reads_done", 32'(reads_done), 32'd1027);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    // Upload request timing
    req_window(-1, -1, -1, -1, -1, pulses, first_at);
    check("req1_cnt", 32'(pulses), 32'd1);
    check("req1_at",  32'(first_at), 32'd17);
    req_window(10, -1, -1, -1, -1, pulses, first_at);
    check("req2_cnt", 32'(pulses), 32'd1);
    check("req2_at",  32'(first_at), 32'd27);
    req_window(-1, 5, 30, -1, -1, pulses, first_at);
    check("req3_cnt", 32'(pulses), 32'd1);
    check("req3_at",  32'(first_at), 32'd43);
    req_window(8, -1, -1, 3, 20, pulses, first_at);
    check("req4_cnt", 32'(pulses), 32'd1);
    check("req4_at",  32'(first_at), 32'd37);
    req_window(-1, -1, -1, 3, 20, pulses, first_at);
    check("req5_cnt", 32'(pulses), 32'd0);

    // Asynchronous reset mid-read with a pending dirty state
    ioctl_upload = 1'b1;
    tick();
    tick();
    cpu_cmos_we = 1'b1;
    tick();
    cpu_cmos_we = 1'b0;
    ioctl_addr  = 17'h003;
    ioctl_rd    = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    check("pre_rst_wait", 32'(ioctl_wait), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_wait", 32'(ioctl_wait), 32'd0);
    check("arst_nvrd", 32'(nv_rd), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_din",  32'(ioctl_din), 32'h00);
    check("arst_addr", 32'(nv_addr), 32'd0);
    tick();
    ioctl_upload = 1'b0;
    tick();
    reset_n = 1'b1;
    pulses  = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (ioctl_upload_req) pulses++;
    end
    check("arst_dirty", 32'(pulses), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nvram_uploader.md
# nvram_uploader

Serves the game's 1K×4 CMOS (high-score/settings NVRAM) to the HPS over the ioctl upload path, the outbound counterpart of the ROM/NVRAM download path. It answers each upload byte read by fetching one nibble from the CMOS read port, stalls the HPS with `ioctl_wait` until the byte is valid, and raises `ioctl_upload_req` after CPU writes to CMOS have gone quiet so the framework saves the file automatically. It sits in the `emu` top level between `hps_io` and the `williams2` core's CMOS second port, in the `clk_sys` (12 MHz) domain.

## Interface
- `ADDR_W`, 10, CMOS address width; the CMOS holds 2^ADDR_W nibbles.
- `NV_INDEX`, 8'd4, `ioctl_index` value that selects the NVRAM file.
- `HOLD`, 24'd12_000_000, quiet cycles after the last CMOS write before the upload request fires (1 s at 12 MHz); must be ≥ 1.

Ports:
- `clk_sys` in 1: system clock; all logic on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `ioctl_upload` in 1: HPS upload in progress.
- `ioctl_download` in 1: HPS download in progress.
- `ioctl_index` in 8: file index of the current transfer.
- `ioctl_addr` in 17: byte address of the requested upload byte.
- `ioctl_rd` in 1: one-cycle read strobe for the byte at `ioctl_addr`.
- `ioctl_din` out 8: upload byte to the HPS.
- `ioctl_wait` out 1: high while `ioctl_din` is not yet valid.
- `ioctl_upload_req` out 1: one-cycle pulse asking the HPS to start an upload.
- `cpu_cmos_we` in 1: CMOS write strobe from the game CPU.
- `nv_addr` out ADDR_W: CMOS read-port address.
- `nv_rd` out 1: CMOS read-port enable.
- `nv_q` in 4: CMOS read data, registered; valid one cycle after `nv_rd`.
- `busy` out 1: high whenever the FSM is not IDLE.

## Operation
- Selected transfer: `sel = ioctl_upload & (ioctl_index == NV_INDEX)`.
- The FSM has three states, IDLE, FETCH and LATCH.
  - IDLE, on `ioctl_rd & sel`: latch the address, assert `ioctl_wait`, go to FETCH.
    - If `ioctl_addr < 2^ADDR_W`, drive `nv_addr <= ioctl_addr[ADDR_W-1:0]` and `nv_rd <= 1`, and clear the internal out-of-range flag `oor`.
    - Otherwise leave `nv_rd` at 0 and set `oor`.
  - FETCH: drop `nv_rd` to 0 and go to LATCH (the RAM registers its output).
  - LATCH: drive `ioctl_din <= oor ? 8'hFF : {4'hF, nv_q}`, drop `ioctl_wait` to 0, go to IDLE.
- `ioctl_rd` is ignored when `sel` is 0 or the FSM is not IDLE. `ioctl_din` holds its last value between reads.
- Byte format is one nibble per byte, low nibble = data and high nibble = F. The file is 2^ADDR_W bytes, byte n = CMOS cell n.
- Dirty tracking uses a `dirty` bit and a 24-bit down-counter `cnt`.
  - `cpu_cmos_we`: `dirty <= 1`, `cnt <= HOLD`. A write always wins over any simultaneous clear.
  - Rising edge of `sel` (upload start) without a same-cycle write: `dirty <= 0`, because the upload captures current contents.
  - `dirty & ~ioctl_upload & ~ioctl_download & cnt != 0`: `cnt <= cnt - 1`.
  - When `dirty & cnt == 0 & ~ioctl_upload & ~ioctl_download` and there is no write: pulse `ioctl_upload_req` for 1 cycle and set `dirty <= 0`.
  - `cnt` freezes during any upload or download. A write during an upload re-arms a later request.

## Timing
- Reset (asynchronous, while `reset_n` = 0) forces:
  - state IDLE;
  - `ioctl_din` = 8'h00;
  - `ioctl_wait`, `ioctl_upload_req`, `nv_rd`, `busy`, `dirty` = 0;
  - `nv_addr` = 0 and `cnt` = 0.
- Read latency, with `ioctl_rd` sampled at edge T0:
  - edge T0: `ioctl_wait` = 1, `nv_rd` = 1.
  - edge T1: `nv_rd` = 0.
  - edge T2: `ioctl_din` valid, `ioctl_wait` = 0.
  - `ioctl_wait` is therefore high for exactly 2 cycles, and the next read is accepted from edge T3.
- Out-of-range reads use the same 2-cycle latency and never assert `nv_rd`.
- Upload request timing: with the last write sampled at edge W, the countdown runs HOLD cycles and `ioctl_upload_req` is high in the cycle after edge W+HOLD+1, provided no upload or download intervenes.
- Reset mid-read: the FSM returns to IDLE and `ioctl_wait` drops immediately. The HPS retry is handled by `hps_io`.
- `busy` = (state != IDLE), registered, and coincides with `ioctl_wait`.

## Test plan
- Preload CMOS[0x005] = 4'hA; `ioctl_index` = 4, upload high, `ioctl_rd` with addr 0x005.
  - Required: `ioctl_wait` high exactly 2 cycles, then `ioctl_din` = 8'hFA; `nv_rd` high 1 cycle with `nv_addr` = 0x005.
- Back-to-back reads of addresses 0..0x3FF with `ioctl_rd` issued when `ioctl_wait` falls.
  - Required: every byte = {F, CMOS[n]}, and no read is dropped.
- `ioctl_rd` with addr 0x400 (index 4).
  - Required: `ioctl_din` = 8'hFF after 2 cycles and `nv_rd` never asserted.
- `ioctl_rd` with `ioctl_index` = 0 (ROM), and a second `ioctl_rd` while `ioctl_wait` = 1.
  - Required: both ignored; `ioctl_wait` stays 0 for the first, and `nv_addr` is unchanged by the second.
- Test with HOLD = 16.
  - One `cpu_cmos_we`: `ioctl_upload_req` pulses once, 17 cycles later.
  - Writes at cycles 0 and 10: a single pulse at cycle 27.
  - `ioctl_download` high from cycle 5 to cycle 30: the pulse is delayed by 26 cycles.
- Test with HOLD = 16: a write, then upload (index 4) starting at cycle 3, and a write during the upload at cycle 8.
  - Required: no request during the upload; one request 17 cycles after the upload ends.
  - Required: asserting `reset_n` = 0 at any point clears `dirty` and all outputs asynchronously.
